// File: rtl/tlc_sensor_if.sv
// tlc_sensor_if: raw loop-sensor inputs and qualified presence/arrival outputs for the sensor conditioner.
interface tlc_sensor_if;
    logic raw_x;
    logic raw_y;
    logic x;
    logic y;
    logic x_arr;
    logic y_arr;
    modport master (output raw_x, raw_y, input x, y, x_arr, y_arr);
    modport slave (input raw_x, raw_y, output x, y, x_arr, y_arr);
endinterface

// File: rtl/tlc_sensor_conditioner.sv
// tlc_sensor_conditioner: synchronizes, debounces and hold-extends two independent loop-sensor channels.
module tlc_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES = 8
) (
    input logic clk,
    input logic reset,
    tlc_sensor_if.slave sif
);
    typedef enum logic [1:0] {IDLE, ARM, PRESENT, HOLD} state_t;
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    logic [1:0] raw;
    logic [1:0] pres;
    logic [1:0] arr;
    assign raw = {sif.raw_y, sif.raw_x};
    assign sif.x = pres[0];
    assign sif.y = pres[1];
    assign sif.x_arr = arr[0];
    assign sif.y_arr = arr[1];
    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t st, nx;
        logic [7:0] cnt, cnt_n;
        logic s1, s2, p, a;
        always_comb begin
            nx = IDLE;
            cnt_n = '0;
            case (st)
                IDLE: begin
                    nx = s2 ? ARM : IDLE;
                    cnt_n = s2 ? 8'd1 : 8'd0;
                end
                ARM: begin
                    nx = !s2 ? IDLE : (cnt == DB_LAST) ? PRESENT : ARM;
                    cnt_n = (s2 && cnt != DB_LAST) ? cnt + 8'd1 : 8'd0;
                end
                PRESENT: begin
                    nx = s2 ? PRESENT : HOLD;
                    cnt_n = s2 ? 8'd0 : 8'd1;
                end
                HOLD: begin
                    nx = s2 ? PRESENT : (cnt == HOLD_LAST) ? IDLE : HOLD;
                    cnt_n = (!s2 && cnt != HOLD_LAST) ? cnt + 8'd1 : 8'd0;
                end
                default: begin
                    nx = IDLE;
                    cnt_n = '0;
                end
            endcase
        end
        // outputs are registered from the next-state decode so they align with the state change
        always_ff @(posedge clk) begin
            if (!reset) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
                st <= IDLE;
                cnt <= '0;
                p <= 1'b0;
                a <= 1'b0;
            end else begin
                s1 <= raw[i];
                s2 <= s1;
                st <= nx;
                cnt <= cnt_n;
                p <= (nx == PRESENT) || (nx == HOLD);
                a <= (st == ARM) && (nx == PRESENT);
            end
        end
        assign pres[i] = p;
        assign arr[i] = a;
    end
endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// tb_tlc_sensor_conditioner: directed and randomized checks of the sensor conditioner against a run-length model.
module tb_tlc_sensor_conditioner;
    localparam int D = 4;
    localparam int H = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic raw_x = 1'b0;
    logic raw_y = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_p [2];
    bit m_a [2];
    int hi [2];
    int lo [2];
    tlc_sensor_if sif ();
    assign sif.raw_x = raw_x;
    assign sif.raw_y = raw_y;
    tlc_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk(clk),
        .reset(reset),
        .sif(sif)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // presence rises after D consecutive synchronized highs, falls after H consecutive lows
    task automatic model_edge();
        bit r [2];
        bit seen;
        r[0] = raw_x;
        r[1] = raw_y;
        for (int c = 0; c < 2; c++) begin
            if (!reset) begin
                m_s1[c] = 0; m_s2[c] = 0; m_p[c] = 0; m_a[c] = 0; hi[c] = 0; lo[c] = 0;
            end else begin
                seen = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = r[c];
                if (seen) begin
                    hi[c] = (hi[c] < 1000) ? hi[c] + 1 : hi[c];
                    lo[c] = 0;
                end else begin
                    lo[c] = (lo[c] < 1000) ? lo[c] + 1 : lo[c];
                    hi[c] = 0;
                end
                m_a[c] = 0;
                if (!m_p[c] && hi[c] >= D) begin
                    m_p[c] = 1;
                    m_a[c] = 1;
                end else if (m_p[c] && lo[c] >= H) begin
                    m_p[c] = 0;
                end
            end
        end
    endtask

    task automatic step(input int k);
        for (int j = 0; j < k; j++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("x", sif.x, m_p[0]);
            check("y", sif.y, m_p[1]);
            check("x_arr", sif.x_arr, m_a[0]);
            check("y_arr", sif.y_arr, m_a[1]);
        end
    endtask

    initial begin
        int run_x, run_y;
        step(3);
        check("reset_x", sif.x, 1'b0);
        check("reset_x_arr", sif.x_arr, 1'b0);
        #1 reset = 1'b1;
        step(4);
        // single-channel qualification latency
        raw_x = 1'b1;
        step(5);
        check("lat_x_pre", sif.x, 1'b0);
        step(1);
        check("lat_x", sif.x, 1'b1);
        check("lat_x_arr", sif.x_arr, 1'b1);
        check("lat_y", sif.y, 1'b0);
        step(1);
        check("lat_x_arr_end", sif.x_arr, 1'b0);
        step(3);
        // release latency
        raw_x = 1'b0;
        step(9);
        check("rel_x_pre", sif.x, 1'b1);
        step(1);
        check("rel_x", sif.x, 1'b0);
        step(3);
        // short glitch is rejected
        raw_x = 1'b1;
        step(3);
        raw_x = 1'b0;
        step(10);
        check("glitch_x", sif.x, 1'b0);
        // short gap keeps presence
        raw_x = 1'b1;
        step(8);
        raw_x = 1'b0;
        step(5);
        raw_x = 1'b1;
        step(6);
        check("gap_x", sif.x, 1'b1);
        raw_x = 1'b0;
        step(12);
        // simultaneous qualification
        raw_x = 1'b1;
        raw_y = 1'b1;
        step(6);
        check("sim_x", sif.x, 1'b1);
        check("sim_y", sif.y, 1'b1);
        check("sim_x_arr", sif.x_arr, 1'b1);
        check("sim_y_arr", sif.y_arr, 1'b1);
        raw_y = 1'b0;
        // reset mid-HOLD, then requalify from scratch
        raw_x = 1'b0;
        step(4);
        check("hold_x", sif.x, 1'b1);
        raw_x = 1'b1;
        reset = 1'b0;
        step(1);
        check("rst_x", sif.x, 1'b0);
        reset = 1'b1;
        step(5);
        check("rst_req_pre", sif.x, 1'b0);
        step(1);
        check("rst_req_x", sif.x, 1'b1);
        check("rst_req_arr", sif.x_arr, 1'b1);
        // random runs with occasional resets
        run_x = 0;
        run_y = 0;
        for (int t = 0; t < 3000; t++) begin
            if (run_x == 0) begin
                raw_x = ~raw_x;
                run_x = $urandom_range(1, 12);
            end
            if (run_y == 0) begin
                raw_y = ~raw_y;
                run_y = $urandom_range(1, 12);
            end
            run_x--;
            run_y--;
            reset = ($urandom_range(0, 199) != 0);
            step(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tlc_sensor_conditioner.md
TLC_SENSOR_CONDITIONER -- requirements
Module: tlc_sensor_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-high samples needed to qualify a vehicle; legal 2..255.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 8: consecutive synchronized-low samples needed to release presence; legal 2..255.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset that is synchronous and active-low, sampled on the rising edge of clk.
REQ-005 The block SHALL have port raw_x, input, 1, asynchronous raw road-1 loop sensor.
REQ-006 The block SHALL have port raw_y, input, 1, asynchronous raw road-2 loop sensor.
REQ-007 The block SHALL have port x, output, 1, qualified road-1 vehicle presence, registered, fed to the light controller's x input.
REQ-008 The block SHALL have port y, output, 1, qualified road-2 vehicle presence, registered, fed to the light controller's y input.
REQ-009 The block SHALL have port x_arr, output, 1, registered one-cycle pulse on each new road-1 qualification.
REQ-010 The block SHALL have port y_arr, output, 1, registered one-cycle pulse on each new road-2 qualification.

Function
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer; the second flop (s2) is the only value the channel FSM samples.
REQ-012 Channels x and y SHALL be identical, independent instances of the same logic, with no cross-coupling.
REQ-013 Each channel SHALL have an FSM with states IDLE, ARM, PRESENT and HOLD, plus an 8-bit counter cnt.
REQ-014 In IDLE, output x (or y) SHALL be 0; on s2=1 the FSM SHALL go to ARM with cnt=1, otherwise stay in IDLE.
REQ-015 In ARM, output SHALL be 0; on s2=0 go to IDLE with cnt=0; on s2=1 with cnt=DEBOUNCE_CYCLES-1 go to PRESENT; on s2=1 otherwise stay in ARM and increment cnt.
REQ-016 In PRESENT, output SHALL be 1; on s2=0 go to HOLD with cnt=1, otherwise stay.
REQ-017 In HOLD, output SHALL be 1; on s2=1 go to PRESENT with cnt=0 and no arrival pulse; on s2=0 with cnt=HOLD_CYCLES-1 go to IDLE; on s2=0 otherwise increment cnt.
REQ-018 x_arr/y_arr SHALL be 1 for exactly the cycle after the ARM->PRESENT edge and 0 at all other times.
REQ-019 Latency: raw held high from before edge 0 SHALL give output 1 after edge DEBOUNCE_CYCLES+1 (after edge 5 at defaults).
REQ-020 Latency: raw held low from before edge 0 while PRESENT SHALL give output 0 after edge HOLD_CYCLES+1 (after edge 9 at defaults).
REQ-021 A high glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave the output at 0 and return the FSM to IDLE.
REQ-022 A low gap shorter than HOLD_CYCLES synchronized samples SHALL keep the output continuously 1 with no new arrival pulse.
REQ-023 cnt SHALL never exceed max(DEBOUNCE_CYCLES,HOLD_CYCLES)-1 and SHALL never wrap.
REQ-024 Simultaneous qualification on both channels SHALL give x=y=1 and x_arr=y_arr=1 in the same cycle.
REQ-025 Any encoding not in the four legal states SHALL go to IDLE with cnt=0 on the next edge.

Reset
REQ-026 While reset=0 at a clk edge, all synchronizer flops, cnt and outputs (x, y, x_arr, y_arr) SHALL become 0 and both FSMs SHALL enter IDLE, including mid-ARM and mid-HOLD.
REQ-027 After reset deasserts, qualification SHALL restart from the full synchronizer plus DEBOUNCE_CYCLES latency; no state is retained from before reset.

Verification
REQ-028 raw_x 0->1 held, defaults -> x=1 and x_arr=1 after edge 5; x_arr=0 after edge 6; y stays 0.
REQ-029 raw_x pulse of 3 cycles -> x never asserts and x_arr never pulses; FSM returns to IDLE.
REQ-030 x PRESENT, then raw_x low for 5 cycles and high again -> x stays 1 throughout and no second x_arr pulse.
REQ-031 x PRESENT, then raw_x low and held -> x=0 after edge 9 counted from the fall.
REQ-032 raw_x and raw_y rise on the same cycle -> x, y, x_arr and y_arr all assert after edge 5.
REQ-033 reset=0 for 1 cycle mid-HOLD with raw_x=1 -> x=0 the next cycle, then x=1 again 6 edges after reset release.
